// File: rtl/mgpu_axi_pkg.sv
// Shared types for the issue-to-AXI4-Lite bridge.
//   - AXI response codes
//   - issue_req_t: one queued scheduler request
//   - bridge_st_t: launch FSM states
package mgpu_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } issue_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_RD = 2'd1,
        SEND_WR = 2'd2
    } bridge_st_t;

endpackage

// File: rtl/mgpu_req_fifo.sv
// Synchronous FIFO of issue_req_t entries.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, wr_data     enqueue (caller guarantees !full)
//   pop, rd_data      dequeue (caller guarantees !empty); rd_data is the head
//   full, empty,count occupancy from registered state
module mgpu_req_fifo
    import mgpu_axi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  issue_req_t               wr_data,
    input  logic                     pop,
    output issue_req_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    issue_req_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W:0]         count_q;

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/issue_axi_bridge.sv
// Scheduler issue stream to single-beat AXI4-Lite master.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   issue_*                 valid/ready request stream from the warp scheduler
//   m_aw*/m_w*/m_b*         AXI-Lite write channels (bready tied high)
//   m_ar*/m_r*              AXI-Lite read channels (rready tied high)
//   rsp_valid/data/err      registered read-data return, one cycle after R
//   clear                   synchronous clear of completion/error counters
//   completed_count         B+R responses received (wraps)
//   error_count             error/unexpected responses (saturates)
//   outstanding             launched but unresponded transactions
//   idle                    FIFO empty, FSM idle, nothing in flight
module issue_axi_bridge
    import mgpu_axi_pkg::*;
#(
    parameter int unsigned REQ_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_addr,
    input  logic        issue_is_write,
    input  logic [31:0] issue_wdata,
    input  logic [3:0]  issue_wstrb,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        clear,
    output logic [31:0] completed_count,
    output logic [15:0] error_count,
    output logic [3:0]  outstanding,
    output logic        idle
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    // Request FIFO
    issue_req_t                  fifo_in;
    issue_req_t                  head;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(REQ_DEPTH):0]  fifo_count;

    assign fifo_in = '{addr: issue_addr, is_write: issue_is_write,
                       wdata: issue_wdata, wstrb: issue_wstrb};
    assign issue_ready = !fifo_full;
    assign fifo_push   = issue_valid && !fifo_full;

    mgpu_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_in),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State
    bridge_st_t  state_q;
    logic        awvalid_q, wvalid_q, arvalid_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q, w_done_q;
    logic        inflight_write_q;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [31:0] completed_q, completed_d;
    logic [15:0] error_q, error_d;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_data_q;

    // Handshakes and launch decision
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic aw_done_n, w_done_n;
    logic launch_ok;

    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;
    assign ar_hs     = m_arvalid && m_arready;
    assign b_hs      = m_bvalid;   // bready is always high
    assign r_hs      = m_rvalid;   // rready is always high
    assign aw_done_n = aw_done_q || aw_hs;
    assign w_done_n  = w_done_q || w_hs;

    // Reads and writes never share the in-flight window.
    assign launch_ok = (fifo_count != '0) && (outstanding_q < MAX_OUT) &&
                       ((outstanding_q == 4'd0) || (head.is_write == inflight_write_q));

    // A transaction counts as launched (and leaves the FIFO) once its
    // address and, for writes, its data have both been accepted.
    assign fifo_pop = ((state_q == SEND_RD) && ar_hs) ||
                      ((state_q == SEND_WR) && aw_done_n && w_done_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            arvalid_q        <= 1'b0;
            awaddr_q         <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            araddr_q         <= '0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            inflight_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_ok) begin
                        inflight_write_q <= head.is_write;
                        if (head.is_write) begin
                            awaddr_q  <= head.addr;
                            wdata_q   <= head.wdata;
                            wstrb_q   <= head.wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= SEND_WR;
                        end else begin
                            araddr_q  <= head.addr;
                            arvalid_q <= 1'b1;
                            state_q   <= SEND_RD;
                        end
                    end
                end
                SEND_RD: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                SEND_WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_n && w_done_n) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response accounting
    logic       any_rsp, unexpected, err_evt;
    logic [3:0] rsp_cnt, retire;

    always_comb begin
        any_rsp    = b_hs || r_hs;
        unexpected = any_rsp && (outstanding_q == 4'd0);
        rsp_cnt    = 4'(b_hs) + 4'(r_hs);
        retire     = 4'd0;
        if (any_rsp && !unexpected) begin
            retire = (rsp_cnt > outstanding_q) ? outstanding_q : rsp_cnt;
        end
        outstanding_d = outstanding_q - retire + 4'(fifo_pop);

        completed_d = completed_q;
        if (any_rsp && !unexpected) begin
            completed_d = completed_q + 32'(rsp_cnt);
        end

        // Simultaneous B and R implies mixed types in flight: flag it.
        err_evt = unexpected || (b_hs && r_hs) ||
                  (b_hs && (m_bresp != RESP_OKAY)) ||
                  (r_hs && (m_rresp != RESP_OKAY));
        error_d = error_q;
        if (err_evt && (error_q != 16'hFFFF)) begin
            error_d = error_q + 16'd1;
        end

        if (clear) begin
            completed_d = '0;
            error_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            completed_q   <= '0;
            error_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            completed_q   <= completed_d;
            error_q       <= error_d;
            rsp_valid_q   <= r_hs;
            if (r_hs) begin
                rsp_data_q <= m_rdata;
                rsp_err_q  <= (m_rresp != RESP_OKAY);
            end
        end
    end

    assign m_awvalid       = awvalid_q;
    assign m_awaddr        = awaddr_q;
    assign m_wvalid        = wvalid_q;
    assign m_wdata         = wdata_q;
    assign m_wstrb         = wstrb_q;
    assign m_arvalid       = arvalid_q;
    assign m_araddr        = araddr_q;
    assign m_bready        = 1'b1;
    assign m_rready        = 1'b1;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign completed_count = completed_q;
    assign error_count     = error_q;
    assign outstanding     = outstanding_q;
    assign idle            = fifo_empty && (state_q == IDLE) && (outstanding_q == 4'd0);

endmodule

// File: tb/tb_issue_axi_bridge.sv
// Bench for issue_axi_bridge: directed scenarios plus randomized traffic,
// checked against a transaction-level model (request queue, in-flight count,
// response counters). Inputs change and outputs are sampled at the falling edge.
module tb_issue_axi_bridge;

    localparam int unsigned REQ_DEPTH = 4;
    localparam int unsigned MAX_OUT   = 4;

    logic        clk;
    logic        rst_n;
    logic        issue_valid, issue_ready, issue_is_write;
    logic [31:0] issue_addr, issue_wdata;
    logic [3:0]  issue_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        rsp_valid, rsp_err, clear, idle;
    logic [31:0] rsp_data, completed_count;
    logic [15:0] error_count;
    logic [3:0]  outstanding;

    issue_axi_bridge #(
        .REQ_DEPTH       (REQ_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .issue_valid (issue_valid), .issue_ready (issue_ready),
        .issue_addr (issue_addr), .issue_is_write (issue_is_write),
        .issue_wdata (issue_wdata), .issue_wstrb (issue_wstrb),
        .m_awvalid (m_awvalid), .m_awready (m_awready), .m_awaddr (m_awaddr),
        .m_wvalid (m_wvalid), .m_wready (m_wready), .m_wdata (m_wdata), .m_wstrb (m_wstrb),
        .m_bvalid (m_bvalid), .m_bready (m_bready), .m_bresp (m_bresp),
        .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
        .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rdata (m_rdata), .m_rresp (m_rresp),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_err (rsp_err),
        .clear (clear), .completed_count (completed_count), .error_count (error_count),
        .outstanding (outstanding), .idle (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Reference model
    req_t        req_q[$];       // accepted, not yet fully launched
    logic [1:0]  pend_q[$];      // in-flight transactions (bresp to return)
    int          exp_out;
    int unsigned exp_comp;
    int          exp_err;
    bit          infl_w, in_send, aw_seen, w_seen;
    bit          exp_rsp_v, exp_rsp_e;
    logic [31:0] exp_rsp_d;
    bit          hold_ar, hold_aw, hold_w;
    logic [31:0] h_araddr, h_awaddr, h_wdata;
    logic [3:0]  h_wstrb;
    bit          auto_slave, auto_issue;

    int tests, fails;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_addr = 0; issue_is_write = 0; issue_wdata = 0; issue_wstrb = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; clear = 0;
    endtask

    task automatic reset_model();
        req_q.delete(); pend_q.delete();
        exp_out = 0; exp_comp = 0; exp_err = 0;
        infl_w = 0; in_send = 0; aw_seen = 0; w_seen = 0;
        exp_rsp_v = 0; exp_rsp_e = 0; exp_rsp_d = 0;
        hold_ar = 0; hold_aw = 0; hold_w = 0;
    endtask

    // Post-edge state compared with the model.
    task automatic check_state();
        check("outstanding", outstanding, exp_out);
        check("completed_count", completed_count, exp_comp);
        check("error_count", error_count, exp_err);
        check("rsp_valid", rsp_valid, exp_rsp_v);
        if (exp_rsp_v) begin
            check("rsp_data", rsp_data, exp_rsp_d);
            check("rsp_err", rsp_err, exp_rsp_e);
        end
        check("issue_ready", issue_ready, req_q.size() < REQ_DEPTH);
        check("idle", idle, (req_q.size() == 0) && (exp_out == 0));
        check("bready_rready", {m_bready, m_rready}, 2'b11);
        if (req_q.size() == 0) check("no_spurious_valid", {m_arvalid, m_awvalid, m_wvalid}, 0);
    endtask

    // Predict everything that happens at the coming rising edge.
    task automatic commit();
        bit   ar_hs, aw_hs, w_hs, launch;
        int   n, pre;
        req_t r;
        if (auto_slave) begin
            m_arready = 1'($urandom); m_awready = 1'($urandom); m_wready = 1'($urandom);
            m_rvalid = 0; m_bvalid = 0;
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                if (infl_w) begin
                    m_bvalid = 1; m_bresp = pend_q[0];
                end else begin
                    m_rvalid = 1; m_rdata = $urandom;
                    m_rresp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                end
            end
        end
        if (auto_issue) begin
            issue_valid = 1'($urandom); issue_addr = $urandom; issue_is_write = 1'($urandom);
            issue_wdata = $urandom; issue_wstrb = 4'($urandom);
            clear = ($urandom_range(0, 63) == 0);
        end

        if (hold_ar) check("ar_hold", {m_arvalid, m_araddr}, {1'b1, h_araddr});
        if (hold_aw) check("aw_hold", {m_awvalid, m_awaddr}, {1'b1, h_awaddr});
        if (hold_w)  check("w_hold", {m_wvalid, m_wdata, m_wstrb}, {1'b1, h_wdata, h_wstrb});

        ar_hs = m_arvalid && m_arready;
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        launch = 0;
        pre = exp_out;

        if (!in_send && (m_arvalid || m_awvalid || m_wvalid) && req_q.size() > 0) begin
            in_send = 1;
            check("launch_gate", (exp_out < MAX_OUT) && (exp_out == 0 || infl_w == req_q[0].wr), 1);
        end
        if (req_q.size() > 0) begin
            if (ar_hs) begin
                check("ar_type", req_q[0].wr, 0);
                check("araddr", m_araddr, req_q[0].addr);
                launch = 1;
            end
            if (aw_hs) begin
                check("aw_type", req_q[0].wr, 1);
                check("awaddr", m_awaddr, req_q[0].addr);
                aw_seen = 1;
            end
            if (w_hs) begin
                check("wdata", m_wdata, req_q[0].wdata);
                check("wstrb", m_wstrb, req_q[0].wstrb);
                w_seen = 1;
            end
            if (aw_seen && w_seen) begin
                launch = 1; aw_seen = 0; w_seen = 0;
            end
        end
        if (m_bvalid || m_rvalid) begin
            if (pre == 0) begin
                if (exp_err < 65535) exp_err++;
            end else begin
                n = int'(m_bvalid) + int'(m_rvalid);
                exp_comp += n;
                exp_out -= (n > pre) ? pre : n;
                if ((m_bvalid && m_bresp != 0) || (m_rvalid && m_rresp != 0) ||
                    (m_bvalid && m_rvalid))
                    if (exp_err < 65535) exp_err++;
                if (pend_q.size() > 0) void'(pend_q.pop_front());
            end
        end
        if (launch) begin
            infl_w = req_q[0].wr;
            void'(req_q.pop_front());
            in_send = 0;
            exp_out++;
            pend_q.push_back(($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00);
        end
        if (clear) begin
            exp_comp = 0; exp_err = 0;
        end
        exp_rsp_v = m_rvalid;
        if (m_rvalid) begin
            exp_rsp_d = m_rdata; exp_rsp_e = (m_rresp != 0);
        end
        if (issue_valid && issue_ready) begin
            r.addr = issue_addr; r.wr = issue_is_write; r.wdata = issue_wdata;
            r.wstrb = issue_wstrb;
            req_q.push_back(r);
        end
        hold_ar = m_arvalid && !ar_hs; h_araddr = m_araddr;
        hold_aw = m_awvalid && !aw_hs; h_awaddr = m_awaddr;
        hold_w  = m_wvalid && !w_hs;   h_wdata = m_wdata; h_wstrb = m_wstrb;
    endtask

    task automatic step();
        commit();
        @(negedge clk);
        check_state();
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws);
        issue_valid = 1; issue_is_write = wr; issue_addr = addr; issue_wdata = wd;
        issue_wstrb = ws;
    endtask

    task automatic drain();
        int k;
        auto_issue = 0; idle_inputs(); auto_slave = 1; k = 0;
        while ((req_q.size() != 0 || exp_out != 0) && k < 400) begin
            step(); k++;
        end
        check("drain_done", (req_q.size() == 0) && (exp_out == 0), 1);
        auto_slave = 0; idle_inputs();
        step();
    endtask

    task automatic do_reset();
        rst_n = 0; idle_inputs(); reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_state();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        tests = 0; fails = 0; auto_slave = 0; auto_issue = 0;
        do_reset();
        check("rst_addr_out", {m_araddr, m_awaddr, m_wdata, m_wstrb}, 0);
        check("rst_ready_idle", {issue_ready, idle}, 2'b11);

        // Single read
        m_arready = 1;
        issue(0, 32'h8000_0000, 0, 0); step(); issue_valid = 0;
        check("rd_t1_arvalid", m_arvalid, 0);
        step();
        check("rd_t2_arvalid", m_arvalid, 1);
        check("rd_t2_araddr", m_araddr, 32'h8000_0000);
        step();
        check("rd_ar_dropped", m_arvalid, 0);
        step(); step();
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 0; step(); m_rvalid = 0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("rd_completed", completed_count, 1);
        check("rd_idle", idle, 1);
        m_arready = 0;

        // Write with W accepted before AW
        issue(1, 32'h8000_0010, 32'h1234_5678, 4'hF); step(); issue_valid = 0;
        step();
        check("wr_both_valid", {m_awvalid, m_wvalid}, 2'b11);
        m_wready = 1; step(); m_wready = 0;
        check("wr_w_dropped", {m_awvalid, m_wvalid}, 2'b10);
        step();
        check("wr_aw_held", m_awvalid, 1);
        m_awready = 1; step(); m_awready = 0;
        check("wr_aw_dropped", m_awvalid, 0);
        check("wr_outstanding", outstanding, 1);
        m_bvalid = 1; m_bresp = 0; step(); m_bvalid = 0;
        check("wr_completed", completed_count, 2);
        check("wr_errors", error_count, 0);

        // Backpressure: 8 reads, no responses
        m_arready = 1; acc = 0;
        for (int k = 0; k < 40 && acc < 8; k++) begin
            issue(0, 32'h1000 + 32'(acc) * 4, 0, 0);
            if (issue_ready) acc++;
            step();
        end
        issue_valid = 0;
        check("bp_accepted", acc, 8);
        repeat (3) step();
        check("bp_outstanding_sat", outstanding, 4);
        check("bp_fifo_full", issue_ready, 0);
        m_rvalid = 1; m_rdata = 32'h0BAD_F00D; step(); m_rvalid = 0;
        repeat (3) step();
        check("bp_relaunch", outstanding, 4);
        check("bp_ready_back", issue_ready, 1);
        drain();

        // Mixed: a queued write waits for the read to retire
        m_arready = 1; m_awready = 1; m_wready = 1;
        issue(0, 32'h2000, 0, 0); step();
        issue(1, 32'h2004, 32'hCAFE_0001, 4'h3); step(); issue_valid = 0;
        repeat (6) step();
        check("mix_wr_held", m_awvalid, 0);
        check("mix_out_rd", outstanding, 1);
        m_rvalid = 1; m_rdata = 32'h5555_AAAA; step(); m_rvalid = 0;
        repeat (4) step();
        check("mix_wr_launched", {outstanding, issue_ready, idle}, {4'd1, 1'b1, 1'b0});
        m_bvalid = 1; m_bresp = 0; step(); m_bvalid = 0;
        check("mix_idle", idle, 1);

        // Errors and clear
        clear = 1; step(); clear = 0;
        check("clr_counts", {completed_count, error_count}, 0);
        issue(1, 32'h3000, 32'h1, 4'h1); step(); issue_valid = 0;
        repeat (3) step();
        m_bvalid = 1; m_bresp = 2'b10; step(); m_bvalid = 0;
        check("err_slverr", error_count, 1);
        m_bvalid = 1; m_bresp = 2'b00; step(); m_bvalid = 0;
        check("err_unexpected", {error_count, outstanding}, {16'd2, 4'd0});
        check("err_unexp_nocount", completed_count, 1);
        m_bvalid = 1; clear = 1; step(); m_bvalid = 0; clear = 0;
        check("err_clear_wins", {completed_count, error_count}, 0);
        m_awready = 0; m_wready = 0; m_arready = 0;

        // Randomized traffic
        auto_slave = 1; auto_issue = 1;
        repeat (2000) step();
        drain();

        // Reset while a read is presented and two entries are queued
        m_arready = 0;
        issue(0, 32'h4000, 0, 0); step();
        issue(0, 32'h4004, 0, 0); step(); issue_valid = 0;
        for (int k = 0; k < 10 && !m_arvalid; k++) step();
        check("rst_pre_arvalid", m_arvalid, 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_valids", {m_arvalid, m_awvalid, m_wvalid, rsp_valid}, 0);
        check("rst_async_addr", m_araddr, 0);
        check("rst_async_state", {issue_ready, idle, outstanding}, {1'b1, 1'b1, 4'd0});
        check("rst_async_counts", {completed_count, error_count}, 0);
        reset_model(); idle_inputs();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        m_arready = 1; m_awready = 1; m_wready = 1;
        repeat (4) step();
        check("rst_after_quiet", {idle, m_arvalid, m_awvalid}, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_axi_bridge.md
# issue_axi_bridge

Mini-GPU memory-side stage directly downstream of the warp scheduler. It accepts the scheduler's issue stream (valid/ready, address, read/write, data, strobe) into a small request FIFO and converts each entry into a single-beat AXI4-Lite master transaction. It tracks outstanding transactions, returns read data, and counts completions and error responses. Those counts are what the scheduler and CSR block use as the real completion signal.

## Interface
Parameters:
- REQ_DEPTH, 4: request FIFO depth; power of two, ≥2
- MAX_OUTSTANDING, 4: max issued-but-unresponded transactions; 1..15

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  request valid
- issue_ready  out  1  FIFO can accept
- issue_addr  in  32  byte address
- issue_is_write  in  1  1 = write, 0 = read
- issue_wdata  in  32  write data
- issue_wstrb  in  4  write byte strobes
- m_awvalid / m_awready / m_awaddr  out/in/out  1/1/32  AXI-Lite AW
- m_wvalid / m_wready / m_wdata / m_wstrb  out/in/out/out  1/1/32/4  AXI-Lite W
- m_bvalid / m_bready / m_bresp  in/out/in  1/1/2  AXI-Lite B
- m_arvalid / m_arready / m_araddr  out/in/out  1/1/32  AXI-Lite AR
- m_rvalid / m_rready / m_rdata / m_rresp  in/out/in/in  1/1/32/2  AXI-Lite R
- rsp_valid  out  1  one-cycle pulse per read response
- rsp_data  out  32  read data, valid with rsp_valid
- rsp_err  out  1  rresp != OKAY, valid with rsp_valid
- clear  in  1  synchronous clear of completed_count/error_count
- completed_count  out  32  B+R responses received, wraps
- error_count  out  16  non-OKAY or unexpected responses, saturates at 0xFFFF
- outstanding  out  4  in-flight transaction count
- idle  out  1  FIFO empty, FSM IDLE, outstanding == 0

## Operation
- Reset values:
  - all valid outputs 0; addr/data/strb outputs 0.
  - issue_ready 1; counters 0; outstanding 0; idle 1.
  - m_bready and m_rready are always 1.
- FIFO: push on issue_valid && issue_ready.
  - issue_ready = !full, derived from registered occupancy.
  - A push into a full FIFO is impossible by construction.
- FSM states IDLE, SEND_RD, SEND_WR.
  - IDLE: if FIFO non-empty and launch gate passes, latch the head into the AXI output registers and go to the type-matching SEND state.
  - Launch gate: outstanding < MAX_OUTSTANDING, and (outstanding == 0 or head type == type of in-flight ops). Reads and writes are never in flight together.
  - SEND_RD: m_arvalid = 1. On m_arready, pop the FIFO, outstanding +1, go to IDLE.
  - SEND_WR: m_awvalid = !aw_done and m_wvalid = !w_done; AW and W handshakes are independent, in either order or the same cycle. When both are done, pop, outstanding +1, clear both flags, go to IDLE.
- AXI rule: addr/data/strb are stable while the corresponding valid is high; a valid is never dropped before its handshake.
- B handshake:
  - completed_count +1.
  - error_count +1 if bresp != 2'b00.
  - outstanding -1.
- R handshake:
  - completed_count +1, outstanding -1.
  - Next cycle: rsp_valid = 1, rsp_data = rdata, rsp_err = (rresp != 0).
- Simultaneous launch and response: outstanding net unchanged. Simultaneous B and R cannot legally occur (single type in flight). If it does, count both, and error_count +1.
- Unexpected response (outstanding == 0): outstanding stays 0, completed_count unchanged, error_count +1.
- clear: zeroes completed_count and error_count; clear wins over a same-cycle increment. FIFO, FSM and outstanding are unaffected.
- Async reset mid-operation: FIFO contents and in-flight tracking are discarded, and all outputs return to reset values immediately.

## Timing
- Issue accepted in cycle T → FIFO head visible T+1 → FSM leaves IDLE at end of T+1 → ARVALID/AWVALID high in T+2.
- With ready already high: handshake in T+2, IDLE in T+3. Peak throughput is one transaction per 2 cycles.
- Read response handshake in cycle R → rsp_valid in R+1 (registered).
- Counters and outstanding update on the edge ending the handshake cycle.
- idle is combinational from registered state.

## Structure
- Package mgpu_axi_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - packed struct issue_req_t {addr[31:0], is_write, wdata[31:0], wstrb[3:0]}
  - enum bridge_st_t {IDLE, SEND_RD, SEND_WR}
- Sub-module mgpu_req_fifo: synchronous FIFO of issue_req_t, REQ_DEPTH entries, full/empty/count outputs, same clk/rst_n.

## Test plan
- **Single read:** addr 0x8000_0000, arready=1, rvalid 3 cycles later with rdata 0xDEAD_BEEF, rresp 0.
  - Expect ARVALID at T+2 with araddr 0x8000_0000.
  - Expect rsp_valid one cycle after R, rsp_data 0xDEAD_BEEF, completed_count 1, idle 1.
- **Write with skewed ready:** addr 0x8000_0010, wdata 0x1234_5678, wstrb 0xF; wready 2 cycles before awready.
  - Expect wvalid to drop after the W handshake and awvalid to hold until its own handshake.
  - One pop; bresp 0 → completed_count 1, error_count 0.
- **Backpressure:** 8 reads, arready=1, no R responses.
  - Expect outstanding to saturate at 4 and the FIFO to fill to 4 with issue_ready 0.
  - Returning one R re-opens one launch.
- **Mixed types:** read then write queued.
  - Expect the write to hold in IDLE until the read's R returns (outstanding 0), then launch.
- **Errors:**
  - bresp SLVERR → error_count 1.
  - Unexpected bvalid with outstanding 0 → error_count 2, outstanding stays 0.
  - clear in the same cycle as a B response → both counters 0.
- **Reset mid-flight:** rst_n low while ARVALID high with 2 FIFO entries.
  - Expect all outputs at reset values the same cycle; after release, idle 1 and no AXI activity.
